// File: rtl/snake_turn_controller.sv
// Snake game input stage.
// Synchronises and debounces the two turn buttons, keeps at most one pending
// relative turn, applies it on game_tik to a one-hot heading, and issues the
// start pulse that launches the game from IDLE or relaunches it from HALT.
module snake_turn_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_BIT         = 18
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       right_P,
    input  logic       left_P,
    input  logic       game_tik,
    input  logic       game_over,
    output logic       right_sync,
    output logic       left_sync,
    output logic       right_register,
    output logic       left_register,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       start,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    // Last counter value before the debounced level is allowed to follow sync.
    localparam logic [CNT_BIT-1:0] DEB_LAST = CNT_BIT'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BIT-1:0] CNT_ONE  = CNT_BIT'(1);

    // Heading is kept in clockwise order {up, right, down, left} so that a
    // quarter turn is a plain rotate of the vector.
    localparam logic [3:0] HEAD_RIGHT = 4'b0100;

    // Button vectors: index 0 is the right button, index 1 the left button.
    logic [1:0] btn_raw;
    logic [1:0] btn_sync;
    logic [1:0] btn_press;

    assign btn_raw = {left_P, right_P};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic               sync1_q;
            logic               sync2_q;
            logic               deb_q;
            logic               deb_d;
            logic               deb_prev_q;
            logic [CNT_BIT-1:0] cnt_q;
            logic [CNT_BIT-1:0] cnt_d;

            // Two-flop synchroniser for the asynchronous raw button.
            always_ff @(posedge clock_25 or posedge reset) begin
                if (reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                end
            end

            // Debounce: count cycles of disagreement, adopt the new level only
            // after it has persisted for the full debounce window.
            always_comb begin
                deb_d = deb_q;
                cnt_d = '0;
                if (sync2_q != deb_q) begin
                    if (cnt_q == DEB_LAST) begin
                        deb_d = sync2_q;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            // Debounce state plus a delayed copy for rising-edge detection.
            always_ff @(posedge clock_25 or posedge reset) begin
                if (reset) begin
                    deb_q      <= 1'b0;
                    deb_prev_q <= 1'b0;
                    cnt_q      <= '0;
                end else begin
                    deb_q      <= deb_d;
                    deb_prev_q <= deb_q;
                    cnt_q      <= cnt_d;
                end
            end

            assign btn_sync[gi]  = sync2_q;
            // One-cycle press on the debounced rising edge only.
            assign btn_press[gi] = deb_q & ~deb_prev_q;
        end
    endgenerate

    // Quarter turns on the {up, right, down, left} vector.
    function automatic logic [3:0] rot_cw(input logic [3:0] h);
        return {h[0], h[3:1]};
    endfunction

    function automatic logic [3:0] rot_ccw(input logic [3:0] h);
        return {h[2:0], h[3]};
    endfunction

    state_t     state_q;
    state_t     state_d;
    logic [3:0] heading_q;
    logic [3:0] heading_d;
    logic       rreg_q;
    logic       rreg_d;
    logic       lreg_q;
    logic       lreg_d;
    logic       start_q;
    logic       start_d;

    logic       press_r;
    logic       press_l;
    logic       press_any;
    logic       press_one;
    logic       pend_r;
    logic       pend_l;

    assign press_r   = btn_press[0];
    assign press_l   = btn_press[1];
    assign press_any = press_r | press_l;
    // Simultaneous presses cancel each other; only a lone press is a turn.
    assign press_one = press_r ^ press_l;

    // Controller next state: game flow, pending turn and heading update.
    always_comb begin
        state_d   = state_q;
        heading_d = heading_q;
        rreg_d    = rreg_q;
        lreg_d    = lreg_q;
        start_d   = 1'b0;
        pend_r    = rreg_q;
        pend_l    = lreg_q;

        case (state_q)
            ST_IDLE: begin
                // The launching press is consumed here and is not a turn.
                if (press_any) begin
                    start_d = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (game_over) begin
                    // Game over wins over a tik or press in the same cycle.
                    state_d = ST_HALT;
                    rreg_d  = 1'b0;
                    lreg_d  = 1'b0;
                end else begin
                    if (game_tik) begin
                        if (rreg_q) begin
                            heading_d = rot_cw(heading_q);
                        end else if (lreg_q) begin
                            heading_d = rot_ccw(heading_q);
                        end
                        // The tik consumes whatever was pending.
                        pend_r = 1'b0;
                        pend_l = 1'b0;
                    end
                    rreg_d = pend_r;
                    lreg_d = pend_l;
                    // First press wins: only latch into an empty slot, which
                    // a coincident tik has just emptied.
                    if (press_one && !pend_r && !pend_l) begin
                        rreg_d = press_r;
                        lreg_d = press_l;
                    end
                end
            end

            ST_HALT: begin
                // Restart only once collision logic has released game_over.
                if (press_any && !game_over) begin
                    heading_d = HEAD_RIGHT;
                    rreg_d    = 1'b0;
                    lreg_d    = 1'b0;
                    start_d   = 1'b1;
                    state_d   = ST_RUN;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                heading_d = HEAD_RIGHT;
                rreg_d    = 1'b0;
                lreg_d    = 1'b0;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            heading_q <= HEAD_RIGHT;
            rreg_q    <= 1'b0;
            lreg_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            heading_q <= heading_d;
            rreg_q    <= rreg_d;
            lreg_q    <= lreg_d;
            start_q   <= start_d;
        end
    end

    assign right_sync     = btn_sync[0];
    assign left_sync      = btn_sync[1];
    assign right_register = rreg_q;
    assign left_register  = lreg_q;
    assign up             = heading_q[3];
    assign right          = heading_q[2];
    assign down           = heading_q[1];
    assign left           = heading_q[0];
    assign start          = start_q;
    assign state          = state_q;

endmodule

// File: tb/tb_snake_turn_controller.sv
// Directed bench for snake_turn_controller with a due-cycle scoreboard.
module tb_snake_turn_controller;

    localparam int DEB = 4;
    localparam int CB  = 3;

    // Heading as {up, down, left, right}.
    localparam logic [3:0] HU = 4'b1000;
    localparam logic [3:0] HD = 4'b0100;
    localparam logic [3:0] HR = 4'b0001;

    logic       clock_25  = 1'b0;
    logic       reset     = 1'b1;
    logic       right_P   = 1'b0;
    logic       left_P    = 1'b0;
    logic       game_tik  = 1'b0;
    logic       game_over = 1'b0;
    logic       right_sync;
    logic       left_sync;
    logic       right_register;
    logic       left_register;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       start;
    logic [1:0] state;

    snake_turn_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_BIT        (CB)
    ) dut (
        .clock_25      (clock_25),
        .reset         (reset),
        .right_P       (right_P),
        .left_P        (left_P),
        .game_tik      (game_tik),
        .game_over     (game_over),
        .right_sync    (right_sync),
        .left_sync     (left_sync),
        .right_register(right_register),
        .left_register (left_register),
        .up            (up),
        .down          (down),
        .left          (left),
        .right         (right),
        .start         (start),
        .state         (state)
    );

    always #5 clock_25 = ~clock_25;

    typedef enum int {F_STATE, F_START, F_HEAD, F_RREG, F_LREG, F_RSYNC, F_LSYNC} field_t;

    typedef struct {
        string      tag;
        int         due;
        field_t     field;
        logic [3:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    function automatic logic [3:0] observe(input field_t f);
        case (f)
            F_STATE: return {2'b00, state};
            F_START: return {3'b000, start};
            F_HEAD:  return {up, down, left, right};
            F_RREG:  return {3'b000, right_register};
            F_LREG:  return {3'b000, left_register};
            F_RSYNC: return {3'b000, right_sync};
            F_LSYNC: return {3'b000, left_sync};
            default: return 4'hx;
        endcase
    endfunction

    task automatic expect_at(input int d, input string tag, input field_t f, input logic [3:0] v);
        exp_t e;
        e.tag   = tag;
        e.due   = cyc + d;
        e.field = f;
        e.exp   = v;
        sb_q.push_back(e);
    endtask

    // Compare every scoreboard entry that falls due on the current cycle.
    task automatic drain();
        exp_t       keep[$];
        exp_t       e;
        logic [3:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.due <= cyc) begin
                obs = observe(e.field);
                checks++;
                assert (obs === e.exp && e.due == cyc) else begin
                    failures++;
                    $error("FAIL %s cyc=%0d due=%0d observed=%0h expected=%0h",
                           e.tag, cyc, e.due, obs, e.exp);
                end
            end else begin
                keep.push_back(e);
            end
        end
        sb_q = keep;
    endtask

    task automatic step();
        @(posedge clock_25);
        #1;
        cyc++;
        drain();
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic tik();
        game_tik = 1'b1;
        step();
        game_tik = 1'b0;
    endtask

    // Hold a button long enough to register, then release and let it settle.
    task automatic push_right();
        right_P = 1'b1;
        steps(10);
        right_P = 1'b0;
        steps(8);
    endtask

    task automatic push_left();
        left_P = 1'b1;
        steps(10);
        left_P = 1'b0;
        steps(8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Power-on reset values
        steps(2);
        expect_at(0, "rst_state", F_STATE, 4'h0);
        expect_at(0, "rst_start", F_START, 4'h0);
        expect_at(0, "rst_head",  F_HEAD,  HR);
        expect_at(0, "rst_rreg",  F_RREG,  4'h0);
        expect_at(0, "rst_lreg",  F_LREG,  4'h0);
        expect_at(0, "rst_rsync", F_RSYNC, 4'h0);
        expect_at(0, "rst_lsync", F_LSYNC, 4'h0);
        drain();
        reset = 1'b0;
        steps(2);

        // IDLE ignores game_tik
        expect_at(1, "idle_tik_state", F_STATE, 4'h0);
        expect_at(1, "idle_tik_head",  F_HEAD,  HR);
        tik();
        steps(2);

        // Launch from IDLE: sync latency, start at edge 7, no turn latched
        expect_at(1, "t2_rsync_e1", F_RSYNC, 4'h0);
        expect_at(2, "t2_rsync_e2", F_RSYNC, 4'h1);
        expect_at(6, "t2_start_e6", F_START, 4'h0);
        expect_at(6, "t2_state_e6", F_STATE, 4'h0);
        expect_at(7, "t2_start_e7", F_START, 4'h1);
        expect_at(7, "t2_state_e7", F_STATE, 4'h1);
        expect_at(8, "t2_start_e8", F_START, 4'h0);
        expect_at(8, "t2_rreg",     F_RREG,  4'h0);
        expect_at(8, "t2_head",     F_HEAD,  HR);
        right_P = 1'b1;
        steps(20);
        right_P = 1'b0;
        steps(8);

        // Short left glitch is filtered
        expect_at(2, "t3_lsync",  F_LSYNC, 4'h1);
        expect_at(8, "t3_glitch", F_LREG,  4'h0);
        left_P = 1'b1;
        steps(3);
        left_P = 1'b0;
        steps(8);

        // Held left press becomes a pending counter-clockwise turn
        expect_at(6, "t3_lreg_e6", F_LREG, 4'h0);
        expect_at(7, "t3_lreg_e7", F_LREG, 4'h1);
        expect_at(7, "t3_rreg_e7", F_RREG, 4'h0);
        push_left();
        expect_at(1, "t3_tik_head", F_HEAD, HU);
        expect_at(1, "t3_tik_lreg", F_LREG, 4'h0);
        tik();
        steps(2);

        // First press wins until the tik
        expect_at(7, "t4_rreg", F_RREG, 4'h1);
        push_right();
        expect_at(8, "t4_rreg_kept", F_RREG, 4'h1);
        expect_at(8, "t4_lreg_ign",  F_LREG, 4'h0);
        push_left();
        expect_at(1, "t4_tik_head", F_HEAD, HR);
        expect_at(1, "t4_tik_rreg", F_RREG, 4'h0);
        tik();
        steps(2);

        // Simultaneous presses are ignored
        expect_at(7, "t4_both_rreg", F_RREG, 4'h0);
        expect_at(7, "t4_both_lreg", F_LREG, 4'h0);
        expect_at(8, "t4_both_rreg8", F_RREG, 4'h0);
        expect_at(8, "t4_both_lreg8", F_LREG, 4'h0);
        right_P = 1'b1;
        left_P  = 1'b1;
        steps(10);
        right_P = 1'b0;
        left_P  = 1'b0;
        steps(8);

        // Tik with nothing pending leaves heading alone
        expect_at(1, "t4_idle_tik", F_HEAD, HR);
        tik();
        steps(2);

        // Press coincident with tik: old turn applied, new one pending
        expect_at(7, "t5_lreg_set", F_LREG, 4'h1);
        push_left();
        expect_at(1, "t5_head_up", F_HEAD, HU);
        tik();
        steps(2);
        expect_at(7, "t5_rreg_set", F_RREG, 4'h1);
        push_right();
        expect_at(6, "t5_head_pre", F_HEAD, HU);
        expect_at(7, "t5_co_head",  F_HEAD, HR);
        expect_at(7, "t5_co_lreg",  F_LREG, 4'h1);
        expect_at(7, "t5_co_rreg",  F_RREG, 4'h0);
        left_P = 1'b1;
        steps(6);
        tik();
        steps(3);
        left_P = 1'b0;
        steps(8);
        expect_at(1, "t5_next_head", F_HEAD, HU);
        expect_at(1, "t5_next_lreg", F_LREG, 4'h0);
        tik();
        steps(2);

        // game_over beats tik and pending turn
        expect_at(7, "t6_rreg_set", F_RREG, 4'h1);
        push_right();
        expect_at(1, "t6_go_state", F_STATE, 4'h2);
        expect_at(1, "t6_go_head",  F_HEAD,  HU);
        expect_at(1, "t6_go_rreg",  F_RREG,  4'h0);
        expect_at(1, "t6_go_start", F_START, 4'h0);
        game_over = 1'b1;
        tik();
        expect_at(1, "t6_halt_tik", F_HEAD, HU);
        tik();
        // Press while game_over is still high: no restart
        expect_at(7, "t6_hold_state", F_STATE, 4'h2);
        expect_at(7, "t6_hold_start", F_START, 4'h0);
        expect_at(8, "t6_hold_start8", F_START, 4'h0);
        push_right();
        game_over = 1'b0;
        step();
        expect_at(7, "t6_re_start", F_START, 4'h1);
        expect_at(7, "t6_re_state", F_STATE, 4'h1);
        expect_at(7, "t6_re_head",  F_HEAD,  HR);
        expect_at(8, "t6_re_start8", F_START, 4'h0);
        push_right();

        // Asynchronous reset mid-run and mid-debounce
        push_right();
        expect_at(1, "t1_head_down", F_HEAD, HD);
        tik();
        steps(2);
        expect_at(7, "t1_rreg_set", F_RREG, 4'h1);
        push_right();
        right_P = 1'b1;
        steps(3);
        reset = 1'b1;
        #2;
        expect_at(0, "t1_rst_head",  F_HEAD,  HR);
        expect_at(0, "t1_rst_rreg",  F_RREG,  4'h0);
        expect_at(0, "t1_rst_lreg",  F_LREG,  4'h0);
        expect_at(0, "t1_rst_state", F_STATE, 4'h0);
        expect_at(0, "t1_rst_start", F_START, 4'h0);
        expect_at(0, "t1_rst_rsync", F_RSYNC, 4'h0);
        drain();
        right_P = 1'b0;
        steps(1);
        reset = 1'b0;
        expect_at(3, "t1_post_state", F_STATE, 4'h0);
        steps(4);

        // Every pushed expectation must have been consumed
        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
